branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Consumer end of the branch-target-buffer prediction path. It records each fetched {pc, predicted target} in an in-flight FIFO and checks it against the real outcome when that instruction resolves in EX. On a mismatch it raises a mispredict/redirect and flushes the wrong-path entries. For every resolved branch it emits the BTB update triple (prev_pc, branch_pc, was_taken) and keeps accuracy counters.

Parameters:
DEPTH, 4, in-flight FIFO entries; power of 2, at least 2
CNT_W, 32, width of statistics counters
INSN_BYTES, 4, fall-through increment added to pc

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  global stall; when low, all state holds and pulse outputs read 0
push_valid  in  1  fetch presents an instruction
push_pc  in  64  fetched pc
push_pred_pc  in  64  BTB predicted target; 0 = no prediction
push_ready  out  1  = !full (no combinational path from other inputs)
res_valid  in  1  EX resolves the oldest in-flight instruction
res_pc  in  64  pc of the resolving instruction
res_is_branch  in  1  instruction is a control transfer
res_taken  in  1  branch taken
res_target  in  64  actual branch target
mispredict  out  1  registered 1-cycle pulse
redirect_pc  out  64  correct next pc, valid with mispredict
upd_valid  out  1  registered 1-cycle pulse, BTB write request
upd_prev_pc  out  64  pc of resolved branch
upd_branch_pc  out  64  res_target
upd_was_taken  out  1  res_taken
desync_err  out  1  sticky: res_pc != head pc, or resolve while empty
branch_cnt  out  CNT_W  resolved branches, saturating
mispred_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, pointers 0, all outputs 0, counters 0, desync_err 0. Reset overrides en and every other input, including mid-flush.
- Push: when en & push_valid & push_ready, write {push_pc, push_pred_pc} at the tail. A push while full is dropped and the tail is unchanged.
- Resolve: when en & res_valid & !empty, pop the head. Occupancy tracks push/pop correctly when both happen in the same cycle. A push and a pop in the same cycle when full is impossible, because push_ready is already low.
- Predicted next pc = (head_pred_pc == 0) ? head_pc + INSN_BYTES : head_pred_pc.
- Actual next pc = (res_is_branch & res_taken) ? res_target : res_pc + INSN_BYTES.
- All additions are modulo 2^64 and wrap silently.
- Mismatch between predicted and actual next pc: on the next cycle mispredict=1 and redirect_pc=actual next pc. The whole FIFO is flushed: pointers reset, count 0. A push accepted in the same cycle is discarded as wrong-path.
- Head check: if res_pc != head_pc, set desync_err, force mispredict, redirect to actual next pc, and flush.
- res_valid while empty: set desync_err; no pop, no pulses.
- BTB update: if res_is_branch on a valid pop, then one cycle later upd_valid=1 with upd_prev_pc=res_pc, upd_branch_pc=res_target, upd_was_taken=res_taken. This fires for taken and not-taken branches alike.
- Counters: branch_cnt += 1 per resolved branch; mispred_cnt += 1 per mispredict pulse. Both hold at 2^CNT_W-1.
- Latency: resolve to mispredict/upd_valid is exactly 1 cycle. Push to resolve-eligible is 1 cycle.
- en=0: no push, no pop, no counter change. Pulse outputs go to 0 next edge; redirect_pc/upd_* data holds.

Decomposition:
- Shared package btb_pkg: PC_W=64, INSN_BYTES, NO_PRED=64'h0, inflight-entry struct {pc, pred_pc}.
- One natural sub-module, pred_fifo: DEPTH-entry synchronous FIFO with push/pop/flush/full/empty. Flush has priority over push.
- The comparison, pulse and counter logic stays in branch_resolve_unit.

Test Plan:
- Push pc=0x100 pred=0, resolve pc=0x100 non-branch -> no mispredict, no upd_valid, FIFO empty, counters 0.
- Push pc=0x200 pred=0x400, resolve taken target=0x400 -> mispredict=0; upd_valid with prev=0x200, branch=0x400, taken=1; branch_cnt=1.
- Push pc=0x300 pred=0, then 0x304 and 0x308; resolve 0x300 taken target=0x800 -> mispredict, redirect_pc=0x800, FIFO empty next cycle, mispred_cnt=1, and the 0x304/0x308 entries are never resolvable.
- Push pc=0x500 pred=0x900, resolve not-taken -> mispredict, redirect_pc=0x504, upd_was_taken=0.
- Push DEPTH=4 entries -> push_ready=0 and a 5th push is dropped; simultaneous push and resolve at count 3 keeps count 3.
- Resolve with empty FIFO -> desync_err=1 and stays set until rst=1; rst mid-stream clears FIFO, counters and outputs on the next edge.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the branch prediction / resolution path.
package btb_pkg;

    localparam int unsigned PC_W       = 64;
    localparam int unsigned INSN_BYTES = 4;
    localparam logic [PC_W-1:0] NO_PRED = '0;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_pc;
    } inflight_t;

endpackage

// File: rtl/pred_fifo.sv
// In-flight prediction FIFO: DEPTH entries, synchronous push/pop, flush beats push and pop.
module pred_fifo
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  inflight_t push_data,
    input  logic      pop,
    input  logic      flush,
    output inflight_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    inflight_t        mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks each resolved instruction against its fetch-time prediction, redirects on mismatch,
// and emits BTB updates plus saturating accuracy counters.
module branch_resolve_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned INSN_BYTES = btb_pkg::INSN_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push_valid,
    input  logic [63:0]      push_pc,
    input  logic [63:0]      push_pred_pc,
    output logic             push_ready,
    input  logic             res_valid,
    input  logic [63:0]      res_pc,
    input  logic             res_is_branch,
    input  logic             res_taken,
    input  logic [63:0]      res_target,
    output logic             mispredict,
    output logic [63:0]      redirect_pc,
    output logic             upd_valid,
    output logic [63:0]      upd_prev_pc,
    output logic [63:0]      upd_branch_pc,
    output logic             upd_was_taken,
    output logic             desync_err,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    import btb_pkg::*;

    localparam logic [PC_W-1:0] INC = PC_W'(INSN_BYTES);

    inflight_t       push_entry, head;
    logic            fifo_full, fifo_empty;
    logic            do_push, do_res, res_on_empty;
    logic [PC_W-1:0] pred_next, act_next;
    logic            mis_now, upd_now;

    logic             mispredict_q, mispredict_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             upd_valid_q, upd_valid_d;
    logic [PC_W-1:0]  upd_prev_pc_q, upd_prev_pc_d;
    logic [PC_W-1:0]  upd_branch_pc_q, upd_branch_pc_d;
    logic             upd_was_taken_q, upd_was_taken_d;
    logic             desync_err_q, desync_err_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    assign push_entry   = '{pc: push_pc, pred_pc: push_pred_pc};
    assign push_ready   = ~fifo_full;
    assign do_push      = en & push_valid & ~fifo_full;
    assign do_res       = en & res_valid & ~fifo_empty;
    assign res_on_empty = en & res_valid & fifo_empty;

    assign pred_next = (head.pred_pc == NO_PRED) ? head.pc + INC : head.pred_pc;
    assign act_next  = (res_is_branch & res_taken) ? res_target : res_pc + INC;
    // A head pc mismatch means the pipelines disagree; redirecting is the only safe recovery.
    assign mis_now   = do_res & ((res_pc != head.pc) | (pred_next != act_next));
    assign upd_now   = do_res & res_is_branch;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .push_data (push_entry),
        .pop       (do_res),
        .flush     (mis_now),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        mispredict_d    = mis_now;
        redirect_pc_d   = redirect_pc_q;
        upd_valid_d     = upd_now;
        upd_prev_pc_d   = upd_prev_pc_q;
        upd_branch_pc_d = upd_branch_pc_q;
        upd_was_taken_d = upd_was_taken_q;
        desync_err_d    = desync_err_q;
        branch_cnt_d    = branch_cnt_q;
        mispred_cnt_d   = mispred_cnt_q;
        if (mis_now) begin
            redirect_pc_d = act_next;
            if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
        if (upd_now) begin
            upd_prev_pc_d   = res_pc;
            upd_branch_pc_d = res_target;
            upd_was_taken_d = res_taken;
            if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (res_on_empty || (do_res && res_pc != head.pc)) desync_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            upd_valid_q     <= 1'b0;
            upd_prev_pc_q   <= '0;
            upd_branch_pc_q <= '0;
            upd_was_taken_q <= 1'b0;
            desync_err_q    <= 1'b0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            upd_valid_q     <= upd_valid_d;
            upd_prev_pc_q   <= upd_prev_pc_d;
            upd_branch_pc_q <= upd_branch_pc_d;
            upd_was_taken_q <= upd_was_taken_d;
            desync_err_q    <= desync_err_d;
            branch_cnt_q    <= branch_cnt_d;
            mispred_cnt_q   <= mispred_cnt_d;
        end
    end

    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign upd_valid     = upd_valid_q;
    assign upd_prev_pc   = upd_prev_pc_q;
    assign upd_branch_pc = upd_branch_pc_q;
    assign upd_was_taken = upd_was_taken_q;
    assign desync_err    = desync_err_q;
    assign branch_cnt    = branch_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model queues expected outputs per cycle.
module tb_branch_resolve_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct {
        logic        mis;
        logic [63:0] redir;
        logic        upd;
        logic [63:0] prev;
        logic [63:0] br;
        logic        tk;
        logic        desync;
        logic [CW-1:0] bcnt;
        logic [CW-1:0] mcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic push_valid = 1'b0;
    logic [63:0] push_pc = '0, push_pred_pc = '0;
    logic push_ready;
    logic res_valid = 1'b0;
    logic [63:0] res_pc = '0;
    logic res_is_branch = 1'b0, res_taken = 1'b0;
    logic [63:0] res_target = '0;
    logic mispredict, upd_valid, upd_was_taken, desync_err;
    logic [63:0] redirect_pc, upd_prev_pc, upd_branch_pc;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] mq_pc[$];
    logic [63:0] mq_pred[$];
    exp_t exp_q[$];
    exp_t m;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DEPTH      (DEPTH),
        .CNT_W      (CW),
        .INSN_BYTES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .push_valid    (push_valid),
        .push_pc       (push_pc),
        .push_pred_pc  (push_pred_pc),
        .push_ready    (push_ready),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_is_branch (res_is_branch),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_prev_pc   (upd_prev_pc),
        .upd_branch_pc (upd_branch_pc),
        .upd_was_taken (upd_was_taken),
        .desync_err    (desync_err),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input exp_t r);
        check_eq("mispredict", 64'(mispredict), 64'(r.mis));
        check_eq("redirect_pc", redirect_pc, r.redir);
        check_eq("upd_valid", 64'(upd_valid), 64'(r.upd));
        check_eq("upd_prev_pc", upd_prev_pc, r.prev);
        check_eq("upd_branch_pc", upd_branch_pc, r.br);
        check_eq("upd_was_taken", 64'(upd_was_taken), 64'(r.tk));
        check_eq("desync_err", 64'(desync_err), 64'(r.desync));
        check_eq("branch_cnt", 64'(branch_cnt), 64'(r.bcnt));
        check_eq("mispred_cnt", 64'(mispred_cnt), 64'(r.mcnt));
        check_eq("push_ready", 64'(push_ready), 64'(mq_pc.size() < DEPTH));
    endtask

    // Reset asserted while other inputs are busy; everything must clear.
    task automatic do_reset();
        rst = 1'b1; en = 1'b1; push_valid = 1'b1; push_pc = 64'h40; push_pred_pc = 64'h0;
        res_valid = 1'b1; res_pc = 64'h40;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0; push_valid = 1'b0; res_valid = 1'b0;
        mq_pc.delete(); mq_pred.delete();
        m = '{mis: 1'b0, redir: '0, upd: 1'b0, prev: '0, br: '0, tk: 1'b0,
              desync: 1'b0, bcnt: '0, mcnt: '0};
        check_outputs(m);
    endtask

    task automatic cycle(input logic e, input logic pv, input logic [63:0] ppc,
                         input logic [63:0] ppred, input logic rv, input logic [63:0] rpc,
                         input logic br, input logic tk, input logic [63:0] tgt);
        logic acc;
        logic [63:0] pn, an;
        en = e; push_valid = pv; push_pc = ppc; push_pred_pc = ppred;
        res_valid = rv; res_pc = rpc; res_is_branch = br; res_taken = tk; res_target = tgt;
        acc = e && pv && (mq_pc.size() < DEPTH);
        m.mis = 1'b0;
        m.upd = 1'b0;
        if (e && rv) begin
            if (mq_pc.size() == 0) begin
                m.desync = 1'b1;
            end else begin
                pn = (mq_pred[0] == 64'h0) ? mq_pc[0] + 64'd4 : mq_pred[0];
                an = (br && tk) ? tgt : rpc + 64'd4;
                if (rpc != mq_pc[0]) m.desync = 1'b1;
                m.mis = (pn != an) || (rpc != mq_pc[0]);
                if (br) begin
                    m.upd = 1'b1; m.prev = rpc; m.br = tgt; m.tk = tk;
                    if (m.bcnt != CMAX) m.bcnt = m.bcnt + 1'b1;
                end
                if (m.mis) begin
                    m.redir = an;
                    if (m.mcnt != CMAX) m.mcnt = m.mcnt + 1'b1;
                    mq_pc.delete(); mq_pred.delete();
                end else begin
                    void'(mq_pc.pop_front()); void'(mq_pred.pop_front());
                end
            end
        end
        if (acc && !m.mis) begin
            mq_pc.push_back(ppc); mq_pred.push_back(ppred);
        end
        exp_q.push_back(m);
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            check_outputs(exp_q.pop_front());
        end
    endtask

    task automatic push_only(input logic [63:0] pc, input logic [63:0] pred);
        cycle(1'b1, 1'b1, pc, pred, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic res_only(input logic [63:0] pc, input logic br, input logic tk,
                            input logic [63:0] tgt);
        cycle(1'b1, 1'b0, '0, '0, 1'b1, pc, br, tk, tgt);
    endtask

    initial begin
        logic [63:0] rpc, tgt;
        do_reset();

        // Non-branch, correctly predicted fall-through
        push_only(64'h100, 64'h0);
        res_only(64'h100, 1'b0, 1'b0, 64'h0);
        // Taken branch predicted correctly
        push_only(64'h200, 64'h400);
        res_only(64'h200, 1'b1, 1'b1, 64'h400);
        // Unpredicted taken branch flushes younger entries
        push_only(64'h300, 64'h0);
        push_only(64'h304, 64'h0);
        push_only(64'h308, 64'h0);
        res_only(64'h300, 1'b1, 1'b1, 64'h800);
        check_eq("empty_after_flush", 64'(push_ready), 64'h1);
        // Predicted taken, actually not taken
        push_only(64'h500, 64'h900);
        res_only(64'h500, 1'b1, 1'b0, 64'h900);
        // Fill, drop overflow, simultaneous push+pop at count 3
        push_only(64'h600, 64'h0);
        push_only(64'h604, 64'h0);
        push_only(64'h608, 64'h0);
        push_only(64'h60c, 64'h0);
        push_only(64'h700, 64'h0);
        res_only(64'h600, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b1, 64'h610, 64'h0, 1'b1, 64'h604, 1'b0, 1'b0, 64'h0);
        push_only(64'h614, 64'h0);
        // Stall: nothing moves, pulses drop
        cycle(1'b0, 1'b1, 64'h900, 64'h0, 1'b1, 64'h608, 1'b1, 1'b1, 64'h0);
        res_only(64'h608, 1'b0, 1'b0, 64'h0);
        res_only(64'h60c, 1'b0, 1'b0, 64'h0);
        res_only(64'h610, 1'b0, 1'b0, 64'h0);
        res_only(64'h614, 1'b0, 1'b0, 64'h0);
        // Fall-through wraps modulo 2^64
        push_only(64'hffff_ffff_ffff_fffc, 64'h0);
        res_only(64'hffff_ffff_ffff_fffc, 1'b0, 1'b0, 64'h0);
        // Resolve on empty sets sticky desync
        res_only(64'h123, 1'b1, 1'b1, 64'h0);
        res_only(64'h123, 1'b0, 1'b0, 64'h0);
        // Head pc mismatch forces redirect and flush
        push_only(64'ha00, 64'h0);
        push_only(64'ha04, 64'h0);
        res_only(64'hb00, 1'b0, 1'b0, 64'h0);
        // Reset mid-stream with entries pending
        push_only(64'hc00, 64'h0);
        push_only(64'hc04, 64'hd00);
        do_reset();

        // Randomised traffic; small counters reach saturation
        for (int i = 0; i < 300; i++) begin
            rpc = $urandom_range(0, 255) * 4;
            tgt = $urandom_range(0, 255) * 4;
            if (mq_pc.size() > 0 && $urandom_range(0, 9) != 0) rpc = mq_pc[0];
            if (mq_pred.size() > 0 && $urandom_range(0, 1) == 1) tgt = mq_pred[0];
            cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  64'($urandom_range(0, 255) * 4),
                  ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 255) * 4) : 64'h0,
                  1'($urandom_range(0, 2) != 0), rpc,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
